blink_req_scheduler: RTL and testbench

Sequencer and two-port round-robin arbiter placed in front of the Blink_128_128 iterative cipher core. It accepts encrypt/decrypt requests (plaintext/ciphertext block, tweak, direction) from two requesters and grants one at a time. It drives the core's operand inputs with a one-cycle load pulse, then counts the core's fixed latency. It captures the core output into a result register with a requester tag and returns it over a valid/ready handshake. Key inputs K0/K1 are static and wired to the core directly; they do not pass through this block.

---
 rtl/blink_req_scheduler.sv | 172 +++++++++++++++++
 tb/tb_blink_req_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/blink_req_scheduler.sv
// blink_req_scheduler
//   Sequencer and two-port round-robin arbiter in front of the Blink_128_128
//   iterative cipher core. One request is in flight at a time: a granted
//   request is latched onto the core operand outputs, the core is started
//   with a one-cycle load pulse, its fixed latency is counted, and the
//   result is returned with a requester tag over a valid/ready handshake.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   reqX_valid/ready      request handshake for requester X (X = 0, 1)
//   reqX_enc/data/tweak   direction, input block and tweak of requester X
//   core_load             one-cycle start pulse to the core
//   core_enc/P/T          operands held stable for the whole core run
//   core_C                core result, valid CORE_LAT cycles after core_load
//   res_valid/ready       result handshake
//   res_data/tag          result block and index of the issuing requester
//   busy                  high whenever the sequencer is not idle
//
// state | meaning
// IDLE  | arbitrate and accept one request
// LOAD  | core_load pulse, counter cleared
// RUN   | counting core latency, capture core_C on the last count
// HOLD  | result presented until the consumer takes it
module blink_req_scheduler #(
    parameter int N        = 128,
    parameter int TW       = 256,
    parameter int CORE_LAT = 16,
    parameter int CW       = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_enc,
    input  logic [N-1:0]  req0_data,
    input  logic [TW-1:0] req0_tweak,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_enc,
    input  logic [N-1:0]  req1_data,
    input  logic [TW-1:0] req1_tweak,
    output logic          core_load,
    output logic          core_enc,
    output logic [N-1:0]  core_P,
    output logic [TW-1:0] core_T,
    input  logic [N-1:0]  core_C,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [N-1:0]  res_data,
    output logic          res_tag,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(CORE_LAT - 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           core_enc_q, core_enc_d;
    logic [N-1:0]   core_p_q, core_p_d;
    logic [TW-1:0]  core_t_q, core_t_d;
    logic           tag_q, tag_d;
    logic           last_grant_q, last_grant_d;
    logic           res_valid_q, res_valid_d;
    logic [N-1:0]   res_data_q, res_data_d;
    logic           res_tag_q, res_tag_d;
    logic           grant0, grant1;

    // On contention the requester that did not win last time is served.
    assign grant0 = req0_valid & (~req1_valid | last_grant_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        core_enc_d   = core_enc_q;
        core_p_d     = core_p_q;
        core_t_d     = core_t_q;
        tag_d        = tag_q;
        last_grant_d = last_grant_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_tag_d    = res_tag_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0) begin
                    core_enc_d   = req0_enc;
                    core_p_d     = req0_data;
                    core_t_d     = req0_tweak;
                    tag_d        = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = LOAD;
                end else if (grant1) begin
                    core_enc_d   = req1_enc;
                    core_p_d     = req1_data;
                    core_t_d     = req1_tweak;
                    tag_d        = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    res_data_d  = core_C;
                    res_tag_d   = tag_q;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            core_enc_q   <= 1'b0;
            core_p_q     <= '0;
            core_t_q     <= '0;
            tag_q        <= 1'b0;
            last_grant_q <= 1'b1;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_tag_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_enc_q   <= core_enc_d;
            core_p_q     <= core_p_d;
            core_t_q     <= core_t_d;
            tag_q        <= tag_d;
            last_grant_q <= last_grant_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_tag_q    <= res_tag_d;
        end
    end

    assign core_load = (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign core_enc  = core_enc_q;
    assign core_P    = core_p_q;
    assign core_T    = core_t_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_tag   = res_tag_q;

endmodule

// File: tb/tb_blink_req_scheduler.sv
// Testbench for blink_req_scheduler: transaction table plus hand-written
// sequences for reset during a core run.
module tb_blink_req_scheduler;

    localparam int N        = 128;
    localparam int TW       = 256;
    localparam int CORE_LAT = 16;
    localparam int CW       = 5;
    localparam int NVEC     = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid, req0_ready, req0_enc;
    logic [N-1:0]  req0_data;
    logic [TW-1:0] req0_tweak;
    logic          req1_valid, req1_ready, req1_enc;
    logic [N-1:0]  req1_data;
    logic [TW-1:0] req1_tweak;
    logic          core_load, core_enc;
    logic [N-1:0]  core_P, core_C;
    logic [TW-1:0] core_T;
    logic          res_valid, res_ready, res_tag, busy;
    logic [N-1:0]  res_data;

    int n_tests = 0;
    int n_fail  = 0;

    blink_req_scheduler #(.N(N), .TW(TW), .CORE_LAT(CORE_LAT), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_enc(req0_enc),
        .req0_data(req0_data), .req0_tweak(req0_tweak),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_enc(req1_enc),
        .req1_data(req1_data), .req1_tweak(req1_tweak),
        .core_load(core_load), .core_enc(core_enc), .core_P(core_P),
        .core_T(core_T), .core_C(core_C),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in cipher function for the core model.
    function automatic logic [N-1:0] cipher(input logic enc, input logic [N-1:0] p,
                                            input logic [TW-1:0] t);
        if (enc) return (p ^ t[N-1:0]) + t[TW-1:N];
        else     return (p ^ t[TW-1:N]) - t[N-1:0];
    endfunction

    // Core model: the result is only correct in the single cycle that lies
    // CORE_LAT cycles after the load pulse; every other cycle shows garbage.
    logic [N-1:0] pend = '0;
    int           cd   = 0;
    always @(posedge clk) begin
        if (core_load) begin
            pend <= cipher(core_enc, core_P, core_T);
            cd   <= CORE_LAT;
        end else if (cd != 0) begin
            cd <= cd - 1;
        end
    end
    assign core_C = (cd == 1) ? pend : ~pend;

    typedef struct {
        logic          v0, v1, e0, e1;
        logic [N-1:0]  d0, d1;
        logic [TW-1:0] t0, t1;
        int            stall;
        int            idle_pre;
        logic          pulse1;
        logic          tag;
    } vec_t;

    vec_t vec[NVEC];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        logic          exp_e;
        logic [N-1:0]  exp_d, exp_r;
        logic [TW-1:0] exp_t;
        logic          bad;
        for (int k = 0; k < v.idle_pre; k++) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            tick();
        end
        req0_valid = v.v0; req0_enc = v.e0; req0_data = v.d0; req0_tweak = v.t0;
        req1_valid = v.v1; req1_enc = v.e1; req1_data = v.d1; req1_tweak = v.t1;
        res_ready  = (v.stall == 0);
        #1;
        exp_e = v.tag ? v.e1 : v.e0;
        exp_d = v.tag ? v.d1 : v.d0;
        exp_t = v.tag ? v.t1 : v.t0;
        exp_r = cipher(exp_e, exp_d, exp_t);
        chk("grant", {req1_ready, req0_ready}, v.tag ? 2'b10 : 2'b01);
        chk("idle_busy", busy, 1'b0);
        tick();
        chk("load_cycle", {core_load, busy, req1_ready, req0_ready}, 4'b1100);
        chk("core_P", core_P, exp_d);
        chk("core_T", core_T, exp_t);
        chk("core_enc", core_enc, exp_e);
        // Requester inputs must not matter after the handshake.
        req0_data = ~req0_data; req0_tweak = ~req0_tweak; req0_enc = ~req0_enc;
        req1_data = ~req1_data; req1_tweak = ~req1_tweak; req1_enc = ~req1_enc;
        bad = 1'b0;
        for (int c = 2; c <= CORE_LAT + 1; c++) begin
            tick();
            if (v.pulse1 && c == 6) begin
                req1_valid = 1'b1;
                #1;
            end
            if (v.pulse1 && c == 7) req1_valid = 1'b0;
            if (core_load !== 1'b0 || res_valid !== 1'b0 || req0_ready !== 1'b0 ||
                req1_ready !== 1'b0 || busy !== 1'b1 || core_P !== exp_d ||
                core_T !== exp_t || core_enc !== exp_e) bad = 1'b1;
        end
        chk("run_quiet", bad, 1'b0);
        tick();
        chk("res_valid", res_valid, 1'b1);
        chk("res_data", res_data, exp_r);
        chk("res_tag", res_tag, v.tag);
        bad = 1'b0;
        for (int s = 1; s <= v.stall; s++) begin
            tick();
            if (res_valid !== 1'b1 || res_data !== exp_r || res_tag !== v.tag ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        if (v.stall > 0) chk("hold_stable", bad, 1'b0);
        res_ready = 1'b1;
        tick();
        chk("idle_after", {busy, res_valid}, 2'b00);
    endtask

    initial begin
        logic bad;
        for (int i = 0; i < NVEC; i++) begin
            vec[i].v0       = 1'b1;
            vec[i].v1       = 1'b1;
            vec[i].e0       = ((i % 2) == 0);
            vec[i].e1       = ((i % 2) == 1);
            vec[i].d0       = {4{32'h0A0B0C00 + 32'(i)}};
            vec[i].d1       = {4{32'h5A000000 ^ (32'(i) * 32'h01010101)}};
            vec[i].t0       = {8{32'h11110000 + 32'(i)}};
            vec[i].t1       = {8{32'hC0DE0000 + 32'(i)}};
            vec[i].stall    = 0;
            vec[i].idle_pre = 0;
            vec[i].pulse1   = 1'b0;
            vec[i].tag      = ((i % 2) == 1);
        end
        vec[0].e0 = 1'b1;
        vec[0].d0 = 128'h00112233445566778899AABBCCDDEEFF;
        vec[0].t0 = 256'h0F1E2D3C4B5A69788796A5B4C3D2E1F00123456789ABCDEFFEDCBA9876543210;
        vec[6].v1 = 1'b0;  vec[6].tag = 1'b0;  vec[6].stall = 5;
        vec[7].v1 = 1'b0;  vec[7].tag = 1'b0;  vec[7].pulse1 = 1'b1;
        vec[8].tag = 1'b1; vec[8].idle_pre = 3;
        vec[9].v1 = 1'b0;  vec[9].tag = 1'b0;  vec[9].e0 = 1'b0;
        vec[10].v0 = 1'b0; vec[10].tag = 1'b1;
        vec[11].tag = 1'b0;

        req0_valid = 1'b0; req0_enc = 1'b0; req0_data = '0; req0_tweak = '0;
        req1_valid = 1'b0; req1_enc = 1'b0; req1_data = '0; req1_tweak = '0;
        res_ready  = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("reset_ctrl", {core_load, core_enc, res_valid, res_tag, busy, req0_ready, req1_ready}, 7'b0);
        chk("reset_core_P", core_P, '0);
        chk("reset_core_T", core_T, '0);
        chk("reset_res_data", res_data, '0);
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            if (i == 10) begin
                // Reset while the core run is at cnt = 7.
                req0_valid = 1'b1; req0_enc = 1'b1;
                req0_data = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
                req0_tweak = {8{32'hA5A5A5A5}};
                req1_valid = 1'b0;
                #1;
                chk("rst_seq_grant", {req1_ready, req0_ready}, 2'b01);
                tick();
                req0_valid = 1'b0;
                for (int c = 0; c < 8; c++) tick();
                chk("rst_seq_running", busy, 1'b1);
                rst = 1'b0;
                #1;
                chk("rst_async_ctrl", {core_load, core_enc, res_valid, res_tag, busy, req0_ready, req1_ready}, 7'b0);
                chk("rst_async_core_P", core_P, '0);
                chk("rst_async_core_T", core_T, '0);
                chk("rst_async_res_data", res_data, '0);
                tick();
                rst = 1'b1;
                bad = 1'b0;
                for (int c = 0; c < 25; c++) begin
                    tick();
                    if (res_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
                end
                chk("no_stale_result", bad, 1'b0);
            end
            run_txn(vec[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
